gac_demux_1t8_reg: RTL and testbench

GAC_DEMUX_1T8_REG -- requirements
Module: gac_demux_1t8_reg

---
 rtl/gac_demux_1t8_reg.sv | 93 +++++++++
 tb/tb_gac_demux_1t8_reg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/gac_demux_1t8_reg.sv
// rtl/gac_demux_1t8_reg.sv - 1-to-8 register demux with one-deep holding stage
module gac_demux_1t8_reg #(
  parameter int WIDTH   = 32,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] d,
  input  logic             out_stall,
  input  logic             clr,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic [7:0]       wr_strobe,
  output logic             busy
);

  logic             busy_r;
  logic [2:0]       sel_r;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] regs [8];
  logic [7:0]       strobe_r;
  logic             accept;
  logic             commit;
  logic             drop;

  // The holding stage frees up whenever it is empty or about to drain.
  assign in_ready = !busy_r || !out_stall;
  // clr wins over both accept and commit on the same edge.
  assign accept   = in_valid && in_ready && !clr;
  assign commit   = busy_r && !out_stall && !clr;
  // A commit to a hardwired-zero entry drains the stage but writes nothing.
  assign drop     = ZERO_R0 && (sel_r == 3'd0);

  // Holding stage: capture on accept, empty on commit without a new accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      sel_r  <= 3'd0;
      d_r    <= '0;
    end else if (clr) begin
      busy_r <= 1'b0;
    end else if (accept) begin
      busy_r <= 1'b1;
      sel_r  <= sel;
      d_r    <= d;
    end else if (commit) begin
      busy_r <= 1'b0;
    end
  end

  // Entry file: only the selected entry loads on a commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (commit && !drop) begin
      regs[sel_r] <= d_r;
    end
  end

  // One-hot commit pulse, visible for the cycle after the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_r <= 8'h00;
    end else if (commit && !drop) begin
      strobe_r <= 8'b1 << sel_r;
    end else begin
      strobe_r <= 8'h00;
    end
  end

  assign busy      = busy_r;
  assign wr_strobe = strobe_r;
  assign q0        = regs[0];
  assign q1        = regs[1];
  assign q2        = regs[2];
  assign q3        = regs[3];
  assign q4        = regs[4];
  assign q5        = regs[5];
  assign q6        = regs[6];
  assign q7        = regs[7];

endmodule

// File: tb/tb_gac_demux_1t8_reg.sv
// tb/tb_gac_demux_1t8_reg.sv - directed table-driven bench for gac_demux_1t8_reg
module tb_gac_demux_1t8_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  sel;
  logic [31:0] d;
  logic        out_stall;
  logic        clr;
  logic [31:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic [7:0]  wr_strobe;
  logic        busy;
  logic [31:0] qa [8];

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic        v;
    logic [2:0]  s;
    logic [31:0] dd;
    logic        st;
    logic        cl;
    logic        rdy;
    logic        bsy;
    logic [7:0]  stb;
    int          idx;
    logic [31:0] val;
  } vec_t;

  vec_t        tbl [11];
  logic [31:0] fin [8];

  gac_demux_1t8_reg #(.WIDTH(32), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .d(d), .out_stall(out_stall), .clr(clr),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
    .wr_strobe(wr_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  assign qa[0] = q0;
  assign qa[1] = q1;
  assign qa[2] = q2;
  assign qa[3] = q3;
  assign qa[4] = q4;
  assign qa[5] = q5;
  assign qa[6] = q6;
  assign qa[7] = q7;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] dd,
                       input logic st, input logic cl);
    in_valid  = v;
    sel       = s;
    d         = dd;
    out_stall = st;
    clr       = cl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s q%0d", tag, i), qa[i], 32'h0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 3, 32'h0};
    tbl[1]  = '{1'b1, 3'd7, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1, 8'h08, 3, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 7, 32'h12345678};
    tbl[3]  = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3, 32'hDEADBEEF};
    tbl[4]  = '{1'b1, 3'd4, 32'h1,        1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 4, 32'h0};
    tbl[5]  = '{1'b1, 3'd4, 32'h2,        1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 4, 32'h1};
    tbl[6]  = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 4, 32'h2};
    tbl[7]  = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4, 32'h2};
    tbl[8]  = '{1'b1, 3'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 0, 32'h0};
    tbl[9]  = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 32'h0};
    tbl[10] = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 32'h0};
    fin = '{32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h2, 32'h0, 32'h0, 32'h12345678};

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst strobe", {24'h0, wr_strobe}, 32'h0);
    chk("rst in_ready", {31'h0, in_ready}, 32'h1);
    chk_all_zero("rst");
    rst_n = 1'b1;

    // Table vectors; the first one is accepted on the first edge after release
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].dd, tbl[i].st, tbl[i].cl);
      #1;
      chk($sformatf("vec%0d in_ready", i), {31'h0, in_ready}, {31'h0, tbl[i].rdy});
      step();
      chk($sformatf("vec%0d busy", i), {31'h0, busy}, {31'h0, tbl[i].bsy});
      chk($sformatf("vec%0d strobe", i), {24'h0, wr_strobe}, {24'h0, tbl[i].stb});
      chk($sformatf("vec%0d q%0d", i, tbl[i].idx), qa[tbl[i].idx], tbl[i].val);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("table final q%0d", i), qa[i], fin[i]);

    // Stall: held write stays put, other requests are refused
    drive(1'b1, 3'd5, 32'hA5A5A5A5, 1'b1, 1'b0);
    #1;
    chk("stall accept in_ready", {31'h0, in_ready}, 32'h1);
    step();
    drive(1'b1, 3'd1, 32'h99, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("stall%0d in_ready", i), {31'h0, in_ready}, 32'h0);
      step();
      chk($sformatf("stall%0d busy", i), {31'h0, busy}, 32'h1);
      chk($sformatf("stall%0d q5", i), q5, 32'h0);
      chk($sformatf("stall%0d strobe", i), {24'h0, wr_strobe}, 32'h0);
    end
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    step();
    chk("unstall q5", q5, 32'hA5A5A5A5);
    chk("unstall strobe", {24'h0, wr_strobe}, 32'h20);
    chk("unstall busy", {31'h0, busy}, 32'h0);
    step();
    chk("unstall strobe gone", {24'h0, wr_strobe}, 32'h0);
    chk("unstall q1 untouched", q1, 32'h0);

    // Clear: fill 1..7, then clr alongside a write to entry 2
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 3'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    step();
    for (int i = 1; i < 8; i++) chk($sformatf("fill q%0d", i), qa[i], 32'h100 + 32'(i));
    drive(1'b1, 3'd2, 32'h11, 1'b0, 1'b1);
    step();
    chk_all_zero("clr");
    chk("clr busy", {31'h0, busy}, 32'h0);
    chk("clr strobe", {24'h0, wr_strobe}, 32'h0);
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    step();
    chk("clr no write q2", q2, 32'h0);
    chk("clr after strobe", {24'h0, wr_strobe}, 32'h0);

    // Asynchronous reset discards a held write
    drive(1'b1, 3'd1, 32'h55, 1'b0, 1'b0);
    step();
    drive(1'b1, 3'd6, 32'h77, 1'b0, 1'b0);
    step();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    chk("pre-reset q1", q1, 32'h55);
    chk("pre-reset busy", {31'h0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async busy", {31'h0, busy}, 32'h0);
    chk("async strobe", {24'h0, wr_strobe}, 32'h0);
    chk_all_zero("async");
    #1;
    rst_n = 1'b1;
    step();
    chk("post-reset q6", q6, 32'h0);
    chk("post-reset busy", {31'h0, busy}, 32'h0);
    chk("post-reset strobe", {24'h0, wr_strobe}, 32'h0);
    drive(1'b1, 3'd2, 32'h33, 1'b0, 1'b0);
    step();
    chk("post-reset accept busy", {31'h0, busy}, 32'h1);
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    step();
    chk("post-reset q2", q2, 32'h33);
    chk("post-reset q2 strobe", {24'h0, wr_strobe}, 32'h04);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
